// File: rtl/ysyx_22040895_idu_pipe.sv
// Pipelined decode stage between IFU and EXU.
// Registered decode fields behind a 2-entry skid buffer.
module ysyx_22040895_idu_pipe #(
  parameter int XLEN = 64,
  parameter int RV64 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] F_R = 3'd0;
  localparam logic [2:0] F_I = 3'd1;
  localparam logic [2:0] F_S = 3'd2;
  localparam logic [2:0] F_B = 3'd3;
  localparam logic [2:0] F_U = 3'd4;
  localparam logic [2:0] F_J = 3'd5;

  localparam logic RV64_EN = (RV64 != 0);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } dec_t;

  state_t state, state_n;
  dec_t   m_q, s_q, dec;
  logic   ld_m, ld_s, m_from_s;
  logic   acc, fire;

  logic        [2:0]  fmt;
  logic               ill;
  logic signed [31:0] imm32;

  always_comb begin
    fmt   = F_R;
    ill   = 1'b0;
    imm32 = '0;
    unique case (in_inst[6:0])
      7'b0110111,
      7'b0010111: fmt = F_U;
      7'b1101111: fmt = F_J;
      7'b1100111,
      7'b0000011,
      7'b0010011,
      7'b1110011: fmt = F_I;
      7'b0011011: begin
        fmt = F_I;
        ill = ~RV64_EN;
      end
      7'b1100011: begin
        fmt = F_B;
        ill = (in_inst[14:13] == 2'b01);
      end
      7'b0100011: fmt = F_S;
      7'b0110011: fmt = F_R;
      7'b0111011: begin
        fmt = F_R;
        ill = ~RV64_EN;
      end
      default: ill = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) ill = 1'b1;
    if (ill) fmt = F_R;

    case (fmt)
      F_I: imm32 = {{20{in_inst[31]}},
                    in_inst[31:20]};
      F_S: imm32 = {{20{in_inst[31]}},
                    in_inst[31:25], in_inst[11:7]};
      F_B: imm32 = {{20{in_inst[31]}},
                    in_inst[7], in_inst[30:25],
                    in_inst[11:8], 1'b0};
      F_U: imm32 = {in_inst[31:12], 12'b0};
      F_J: imm32 = {{12{in_inst[31]}},
                    in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec.pc      = in_pc;
    dec.opcode  = in_inst[6:0];
    dec.func3   = in_inst[14:12];
    dec.func7   = in_inst[31:25];
    dec.imm     = XLEN'(imm32);
    dec.fmt     = fmt;
    dec.illegal = ill;
    dec.rs1     = in_inst[19:15];
    dec.rs2     = in_inst[24:20];
    dec.rd      = in_inst[11:7];
    if (fmt == F_U || fmt == F_J) dec.rs1 = '0;
    if (fmt == F_U || fmt == F_J || fmt == F_I)
      dec.rs2 = '0;
    if (fmt == F_S || fmt == F_B) dec.rd = '0;
    if (ill) begin
      dec.rs1 = '0;
      dec.rs2 = '0;
      dec.rd  = '0;
    end
  end

  assign in_ready  = ~rst & (state != TWO);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_n  = state;
    ld_m     = 1'b0;
    ld_s     = 1'b0;
    m_from_s = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc) begin
          ld_m    = 1'b1;
          state_n = ONE;
        end
        ONE: begin
          if (acc && fire) begin
            ld_m = 1'b1;
          end else if (acc) begin
            ld_s    = 1'b1;
            state_n = TWO;
          end else if (fire) begin
            state_n = EMPTY;
          end
        end
        TWO: if (fire) begin
          m_from_s = 1'b1;
          state_n  = ONE;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      state <= state_n;
      if (ld_m) m_q <= dec;
      else if (m_from_s) m_q <= s_q;
      if (ld_s) s_q <= dec;
    end
  end

  assign out_pc      = m_q.pc;
  assign out_opcode  = m_q.opcode;
  assign out_func3   = m_q.func3;
  assign out_func7   = m_q.func7;
  assign out_rs1     = m_q.rs1;
  assign out_rs2     = m_q.rs2;
  assign out_rd      = m_q.rd;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_ysyx_22040895_idu_pipe.sv
// Bench for the pipelined decode stage: queue model
// of the handshake plus a rule-level decode model.
module tb_ysyx_22040895_idu_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, flush;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_imm;
  logic [6:0]  out_opcode, out_func7;
  logic [2:0]  out_func3, out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_illegal;

  logic        rv_in_ready, rv_out_valid;
  logic [63:0] rv_out_pc, rv_out_imm;
  logic [6:0]  rv_out_opcode, rv_out_func7;
  logic [2:0]  rv_out_func3, rv_out_fmt;
  logic [4:0]  rv_out_rs1, rv_out_rs2, rv_out_rd;
  logic        rv_out_illegal;

  always #5 clk = ~clk;

  ysyx_22040895_idu_pipe #(.XLEN(64), .RV64(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode),
    .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  ysyx_22040895_idu_pipe #(.XLEN(64), .RV64(0)) dut_rv32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rv_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(rv_out_valid), .out_ready(1'b1),
    .out_pc(rv_out_pc), .out_opcode(rv_out_opcode),
    .out_func3(rv_out_func3), .out_func7(rv_out_func7),
    .out_rs1(rv_out_rs1), .out_rs2(rv_out_rs2),
    .out_rd(rv_out_rd), .out_imm(rv_out_imm),
    .out_fmt(rv_out_fmt), .out_illegal(rv_out_illegal)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   fired  = 0;
  ent_t q[$];

  function automatic ent_t model(logic [31:0] i,
                                 logic [63:0] pc);
    ent_t   e;
    int     f;
    bit     legal;
    longint v;
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    legal = 1;
    f = 0;
    v = 0;
    if (op == 7'h37 || op == 7'h17) f = 4;
    else if (op == 7'h6F) f = 5;
    else if (op == 7'h67 || op == 7'h03 ||
             op == 7'h13 || op == 7'h73 ||
             op == 7'h1B) f = 1;
    else if (op == 7'h63) begin
      f = 3;
      legal = !(f3 == 3'd2 || f3 == 3'd3);
    end
    else if (op == 7'h23) f = 2;
    else if (op == 7'h33 || op == 7'h3B) f = 0;
    else legal = 0;
    if (i[1:0] != 2'b11) legal = 0;
    e.pc = pc;
    e.op = op;
    e.f3 = f3;
    e.f7 = i[31:25];
    if (!legal) begin
      e.rs1 = 0; e.rs2 = 0; e.rd = 0;
      e.imm = 0; e.fmt = 0; e.ill = 1;
      return e;
    end
    case (f)
      1: begin
        v = longint'(i[31:20]);
        if (i[31]) v -= 4096;
      end
      2: begin
        v = longint'({i[31:25], i[11:7]});
        if (i[31]) v -= 4096;
      end
      3: begin
        v = longint'({i[31], i[7], i[30:25],
                      i[11:8], 1'b0});
        if (i[31]) v -= 8192;
      end
      4: begin
        v = longint'({i[31:12], 12'b0});
        if (i[31]) v -= (longint'(1) << 32);
      end
      5: begin
        v = longint'({i[31], i[19:12], i[20],
                      i[30:21], 1'b0});
        if (i[31]) v -= (longint'(1) << 21);
      end
      default: v = 0;
    endcase
    e.imm = v;
    e.fmt = 3'(f);
    e.ill = 0;
    e.rs1 = (f == 4 || f == 5) ? 5'd0 : i[19:15];
    e.rs2 = (f == 0 || f == 2 || f == 3) ?
            i[24:20] : 5'd0;
    e.rd  = (f == 2 || f == 3) ? 5'd0 : i[11:7];
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        fired++;
      end
      if (in_valid && in_ready)
        q.push_back(model(in_inst, in_pc));
    end
  end

  always @(negedge clk) begin
    ent_t got;
    if (!rst) begin
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL in_ready got %b exp %b",
                 in_ready, q.size() < 2);
      end
      checks++;
      if (out_valid !== (q.size() > 0)) begin
        errors++;
        $display("FAIL out_valid got %b exp %b",
                 out_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        got = {out_pc, out_opcode, out_func3,
               out_func7, out_rs1, out_rs2, out_rd,
               out_imm, out_fmt, out_illegal};
        checks++;
        if (got !== q[0]) begin
          errors++;
          $display("FAIL entry got %h exp %h",
                   got, q[0]);
        end
      end
    end
  end

  task automatic lit(string n, logic [63:0] got,
                     logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask

  task automatic send(logic [31:0] i, logic [63:0] p);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout got %0d exp <50", n);
    end
    in_inst  = i;
    in_pc    = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [31:0] bad[3];
  int f0, n;

  initial begin
    in_valid  = 0;
    in_inst   = 0;
    in_pc     = 0;
    flush     = 0;
    out_ready = 1;
    repeat (2) @(negedge clk);
    lit("rst_out_valid", 64'(out_valid), 0);
    lit("rst_in_ready", 64'(in_ready), 0);
    lit("rst_imm", out_imm, 0);
    lit("rst_pc", out_pc, 0);
    rst = 0;
    #1;
    lit("post_rst_in_ready", 64'(in_ready), 1);
    lit("post_rst_out_valid", 64'(out_valid), 0);
    @(negedge clk);

    send(32'hFFF10093, 64'h1000);
    lit("addi_fmt", 64'(out_fmt), 1);
    lit("addi_rs1", 64'(out_rs1), 2);
    lit("addi_rs2", 64'(out_rs2), 0);
    lit("addi_rd", 64'(out_rd), 1);
    lit("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    send(32'hFE208EE3, 64'h1004);
    lit("beq_fmt", 64'(out_fmt), 3);
    lit("beq_rs1", 64'(out_rs1), 1);
    lit("beq_rs2", 64'(out_rs2), 2);
    lit("beq_rd", 64'(out_rd), 0);
    lit("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    send(32'h008000EF, 64'h1008);
    lit("jal_fmt", 64'(out_fmt), 5);
    lit("jal_rd", 64'(out_rd), 1);
    lit("jal_imm", out_imm, 64'h8);
    send(32'h800002B7, 64'h100C);
    lit("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
    lit("lui_rd", 64'(out_rd), 5);
    @(negedge clk);

    out_ready = 0;
    f0 = fired;
    send(32'h00308113, 64'h2000);
    send(32'h002081B3, 64'h2004);
    lit("bp_in_ready", 64'(in_ready), 0);
    lit("bp_head_pc", out_pc, 64'h2000);
    in_inst  = 32'h00112223;
    in_pc    = 64'h2008;
    in_valid = 1;
    repeat (3) @(negedge clk);
    lit("bp_hold_pc", out_pc, 64'h2000);
    lit("bp_hold_ready", 64'(in_ready), 0);
    out_ready = 1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 0;
    repeat (4) @(negedge clk);
    lit("bp_delivered", 64'(fired - f0), 3);
    lit("bp_drained", 64'(out_valid), 0);

    out_ready = 0;
    send(32'h00A00513, 64'h3000);
    send(32'h00B00593, 64'h3004);
    f0 = fired;
    flush    = 1;
    in_valid = 1;
    in_inst  = 32'h00C00613;
    in_pc    = 64'h3008;
    @(negedge clk);
    flush    = 0;
    in_valid = 0;
    lit("fl2_out_valid", 64'(out_valid), 0);
    lit("fl2_in_ready", 64'(in_ready), 1);
    out_ready = 1;
    repeat (3) @(negedge clk);
    lit("fl2_none", 64'(fired - f0), 0);
    out_ready = 0;
    send(32'h00D00693, 64'h4000);
    flush    = 1;
    in_valid = 1;
    in_inst  = 32'h00E00713;
    in_pc    = 64'h4004;
    @(negedge clk);
    flush    = 0;
    in_valid = 0;
    lit("fl1_out_valid", 64'(out_valid), 0);
    out_ready = 1;
    repeat (2) @(negedge clk);

    bad[0] = 32'h00000000;
    bad[1] = 32'h0000207B;
    bad[2] = 32'h00002063;
    for (int k = 0; k < 3; k++) begin
      send(bad[k], 64'h5000 + 64'(4 * k));
      lit("ill_flag", 64'(out_illegal), 1);
      lit("ill_imm", out_imm, 0);
      lit("ill_fmt", 64'(out_fmt), 0);
    end
    send(32'h0010009B, 64'h6000);
    lit("addiw_rv64_ill", 64'(out_illegal), 0);
    lit("addiw_rv64_imm", out_imm, 1);
    lit("addiw_rv32_vld", 64'(rv_out_valid), 1);
    lit("addiw_rv32_ill", 64'(rv_out_illegal), 1);
    lit("addiw_rv32_imm", rv_out_imm, 0);
    @(negedge clk);

    out_ready = 0;
    send(32'hFFF10093, 64'h7000);
    lit("pre_rst_valid", 64'(out_valid), 1);
    #2;
    rst = 1;
    #1;
    lit("arst_valid", 64'(out_valid), 0);
    lit("arst_in_ready", 64'(in_ready), 0);
    lit("arst_imm", out_imm, 0);
    lit("arst_pc", out_pc, 0);
    lit("arst_rd", 64'(out_rd), 0);
    lit("arst_fmt", 64'(out_fmt), 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    lit("after_rst_valid", 64'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_idu_pipe.md
Name: ysyx_22040895_idu_pipe

Overview:
Parametrised, pipelined successor to the combinational decode stage. Sits between IFU and EXU. Accepts {inst, pc} through a valid/ready handshake and decodes it. Emits registered decode fields with a fully assembled, sign-extended XLEN immediate, a format code, and an illegal-instruction flag. Contains a 2-entry skid buffer so back-pressure from the EXU never creates a combinational path to the IFU.

Parameters:
XLEN, 64, datapath and PC width; the immediate is sign-extended to XLEN.
RV64, 1, when 1, opcodes OP-IMM-32 (0011011) and OP-32 (0111011) are legal; when 0 they decode as illegal.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  IFU presents an instruction
in_ready  out  1  stage can accept; transfer happens when in_valid & in_ready
in_inst  in  32  raw instruction
in_pc  in  XLEN  instruction PC
flush  in  1  kill all buffered entries (branch redirect)
out_valid  out  1  decoded entry presented to EXU
out_ready  in  1  EXU accepts; transfer happens when out_valid & out_ready
out_pc  out  XLEN  PC of the presented entry
out_opcode  out  7  inst[6:0]
out_func3  out  3  inst[14:12]
out_func7  out  7  inst[31:25]
out_rs1  out  5  rs1 index, 0 if unused
out_rs2  out  5  rs2 index, 0 if unused
out_rd  out  5  rd index, 0 if unused
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5
out_illegal  out  1  instruction not decodable

Behaviour:
- Reset (async, rst=1): both entries are invalid. out_valid=0 and in_ready=0 while rst is high. All out_* data fields are 0.
- First cycle after rst deasserts: in_ready=1.
- Decode is combinational on in_inst and is captured on acceptance. Latency is 1 cycle: an instruction accepted at edge N is presented on out_* after edge N.
- State machine, based on the occupancy of the main register M and skid register S:
  - EMPTY: in_ready=1. On accept, go to ONE.
  - ONE (M valid): in_ready=1.
    - Accept and out-fire: M is reloaded; stay in ONE.
    - Accept with no out-fire: the new entry goes to S; go to TWO.
    - Out-fire with no accept: go to EMPTY.
  - TWO (M and S valid): in_ready=0 (a registered signal).
    - Out-fire: S moves to M; go to ONE.
- out_* always reflect M. The data fields hold their value while out_valid=1 and out_ready=0.
- Flush has priority over every other event in the same cycle. Next state is EMPTY, and any same-cycle acceptance is discarded. out_valid=0 on the following cycle.
- Data fields are don't-care when out_valid=0, except after reset, when they are 0.
- Immediates, sign-extended from the top bit to XLEN:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}
  - R: 0
- Opcode to format mapping:
  - LUI 0110111 and AUIPC 0010111: U
  - JAL 1101111: J
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, SYSTEM 1110011: I
  - BRANCH 1100011: B
  - STORE 0100011: S
  - OP 0110011, OP-32 0111011: R
- Register index masking:
  - U and J: rs1=rs2=0.
  - I: rs2=0.
  - S and B: rd=0.
  - R: all three passed through.
- Illegal conditions:
  - inst[1:0] != 2'b11
  - an unlisted opcode
  - BRANCH with func3 = 010 or 011
  - a *-32 opcode when RV64=0
- On an illegal instruction: out_illegal=1, out_fmt=R, out_imm=0, rs1=rs2=rd=0. The entry still flows through the handshake normally.
- Reset mid-operation discards both entries immediately.

Test Plan:
1. After reset, present 0xFFF10093 (addi x1,x2,-1) with out_ready=1. Next cycle: out_valid=1, out_fmt=1, rs1=2, rs2=0, rd=1, out_imm=0xFFFFFFFFFFFFFFFF.
2. Present 0xFE208EE3 (beq x1,x2,-4). Expect out_fmt=3, rs1=1, rs2=2, rd=0, out_imm=0xFFFFFFFFFFFFFFFC. Then 0x008000EF (jal x1,+8): out_fmt=5, rd=1, out_imm=0x8. Then 0x800002B7 (lui x5): out_imm=0xFFFFFFFF80000000.
3. Back-pressure: hold out_ready=0 and stream three instructions. Expect in_ready=0 after the second accept and the first entry held stable on out_*. Release out_ready: expect in-order delivery and no loss or duplication.
4. In the TWO state, assert flush together with in_valid=1. Next cycle: out_valid=0, in_ready=1, and the flushed entries never appear.
5. Illegal inputs: 0x00000000, 0x0000207B, and 0x00002063 (BRANCH func3=010). Each gives out_illegal=1, out_imm=0, out_fmt=0. With RV64=0, 0x0010009B (addiw) also gives out_illegal=1.
6. Assert rst asynchronously while out_valid=1. out_valid drops before the next clock edge, and all out_* fields read 0.
